// File: rtl/tile_arbiter.sv
// Tile colour RAM for a COLS x ROWS grid of BSIZE-pixel blocks. Scanout owns fixed
// read slots; a whole-grid clear and two round-robin writers share the other cycles.
module tile_arbiter #(
    parameter int COLS    = 16,
    parameter int ROWS    = 12,
    parameter int BSIZE   = 40,
    parameter int HPIXELS = 640,
    parameter int HTOTAL  = 800,
    parameter int VLINES  = 480,
    parameter int VTOTAL  = 525
) (
    input  logic        vgaclk,
    input  logic        rst,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        req0,
    input  logic [7:0]  addr0,
    input  logic [11:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [7:0]  addr1,
    input  logic [11:0] data1,
    output logic        ack1,
    input  logic        clr,
    input  logic [11:0] clr_color,
    output logic        busy,
    output logic        err,
    output logic [3:0]  red_out,
    output logic [3:0]  green_out,
    output logic [3:0]  blue_out
);
    localparam int NTILES = COLS * ROWS;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [11:0] r_mem [0:NTILES-1];
    logic [0:0]  r_state;
    logic [7:0]  r_ptr;
    logic [11:0] r_fill;
    logic [11:0] r_pix;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_err;
    logic        r_last;

    logic [10:0] w_hc1;
    logic [9:0]  w_nv;
    logic        w_slot_mid;
    logic        w_slot_sol;
    logic        w_slot;
    logic        w_free;
    logic [7:0]  w_raddr;
    logic        w_elig0;
    logic        w_elig1;
    logic        w_arb_ok;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_gnt;
    logic [7:0]  w_gaddr;
    logic [11:0] w_gdata;
    logic        w_inrange;
    logic        w_clr_we;
    logic        w_we;
    logic [7:0]  w_waddr;
    logic [11:0] w_wdata;

    // Scan slots sit one cycle before each tile boundary so pix changes right on it.
    assign w_hc1      = {1'b0, hc} + 11'd1;
    assign w_nv       = (vc == 10'(VTOTAL - 1)) ? 10'd0 : vc + 10'd1;
    assign w_slot_mid = (vc < 10'(VLINES)) && ((w_hc1 % 11'(BSIZE)) == 11'd0)
                        && (w_hc1 < 11'(HPIXELS));
    assign w_slot_sol = (hc == 10'(HTOTAL - 1)) && (w_nv < 10'(VLINES));
    assign w_slot     = w_slot_mid | w_slot_sol;
    assign w_free     = ~w_slot;

    assign w_raddr = w_slot_sol
                   ? 8'(int'(w_nv / 10'(BSIZE)) * COLS)
                   : 8'(int'(vc / 10'(BSIZE)) * COLS + int'(w_hc1 / 11'(BSIZE)));

    // A requester whose ack is showing has already been served for this request.
    assign w_elig0  = req0 & ~r_ack0;
    assign w_elig1  = req1 & ~r_ack1;
    assign w_arb_ok = (r_state == S_IDLE) & w_free & ~clr;
    assign w_gnt0   = w_arb_ok & w_elig0 & (~w_elig1 | r_last);
    assign w_gnt1   = w_arb_ok & w_elig1 & (~w_elig0 | ~r_last);
    assign w_gnt    = w_gnt0 | w_gnt1;

    assign w_gaddr   = w_gnt1 ? addr1 : addr0;
    assign w_gdata   = w_gnt1 ? data1 : data0;
    assign w_inrange = w_gaddr < 8'(NTILES);
    assign w_clr_we  = (r_state == S_CLEAR) & w_free;

    assign w_we    = rst & (w_clr_we | (w_gnt & w_inrange));
    assign w_waddr = w_clr_we ? r_ptr : w_gaddr;
    assign w_wdata = w_clr_we ? r_fill : w_gdata;

    always_ff @(posedge vgaclk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_fill  <= '0;
            r_pix   <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_ack0 <= w_gnt0;
            r_ack1 <= w_gnt1;
            r_err  <= w_gnt & ~w_inrange;
            if (w_gnt) begin
                r_last <= w_gnt1;
            end
            if (w_slot) begin
                r_pix <= r_mem[w_raddr];
            end
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= '0;
                        r_fill  <= clr_color;
                    end
                end
                S_CLEAR: begin
                    if (w_free) begin
                        if (r_ptr == 8'(NTILES - 1)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_ptr <= r_ptr + 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign err       = r_err;
    assign busy      = (r_state == S_CLEAR);
    assign red_out   = r_pix[11:8];
    assign green_out = r_pix[7:4];
    assign blue_out  = r_pix[3:0];

endmodule

// File: tb/tb_tile_arbiter.sv
// Bench for tile_arbiter: drives hc/vc directly, tracks expected RAM contents and
// expected acks in a scoreboard, and sweeps scan lines against the expected tiles.
module tb_tile_arbiter;
    logic        vgaclk = 1'b0;
    logic        rst;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        req0;
    logic [7:0]  addr0;
    logic [11:0] data0;
    logic        ack0;
    logic        req1;
    logic [7:0]  addr1;
    logic [11:0] data1;
    logic        ack1;
    logic        clr;
    logic [11:0] clr_color;
    logic        busy;
    logic        err;
    logic [3:0]  red_out;
    logic [3:0]  green_out;
    logic [3:0]  blue_out;

    tile_arbiter dut (
        .vgaclk    (vgaclk),
        .rst       (rst),
        .hc        (hc),
        .vc        (vc),
        .req0      (req0),
        .addr0     (addr0),
        .data0     (data0),
        .ack0      (ack0),
        .req1      (req1),
        .addr1     (addr1),
        .data1     (data1),
        .ack1      (ack1),
        .clr       (clr),
        .clr_color (clr_color),
        .busy      (busy),
        .err       (err),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out)
    );

    always #5 vgaclk = ~vgaclk;

    // Scoreboard entry: {requester, err, addr, data}.
    localparam int W = 22;
    logic [W-1:0] exp_q[$];
    logic [11:0]  exp_mem [0:191];
    logic         prev_ack0 = 1'b0;
    logic         prev_ack1 = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    typedef struct {
        logic        sel;
        logic [7:0]  addr;
        logic [11:0] data;
        int          h;
        int          v;
        logic        exp_err;
        int          exp_lat;
    } wr_vec_t;

    wr_vec_t vecs [8];

    task automatic check(input bit ok, input string name, input int act, input int expv);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (hc=%0d vc=%0d)", name, act, expv, hc, vc);
        end
    endtask

    task automatic monitor();
        logic [W-1:0] e;
        if (busy === 1'b1) begin
            check((ack0 | ack1) === 1'b0, "ack_during_busy", {ack1, ack0}, 0);
        end
        if ((ack0 | ack1) === 1'b1) begin
            if (ack0) check(prev_ack0 === 1'b0, "ack0_one_cycle", prev_ack0, 0);
            if (ack1) check(prev_ack1 === 1'b0, "ack1_one_cycle", prev_ack1, 0);
            check(exp_q.size() != 0, "unexpected_ack", {ack1, ack0}, 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(ack1 === e[21] && ack0 === ~e[21], "ack_order", {ack1, ack0},
                      e[21] ? 2 : 1);
                check(err === e[20], "err_flag", err, e[20]);
                if (!e[20]) exp_mem[e[19:12]] = e[11:0];
            end
        end else begin
            check(err === 1'b0, "err_without_ack", err, 0);
        end
        prev_ack0 = ack0;
        prev_ack1 = ack1;
    endtask

    task automatic cycle();
        @(posedge vgaclk);
        #1;
        if (hc == 10'd799) begin
            hc = 10'd0;
            vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
        end else begin
            hc = hc + 10'd1;
        end
        monitor();
    endtask

    task automatic set_pos(input int h, input int v);
        hc = 10'(h);
        vc = 10'(v);
    endtask

    task automatic drive_req(input logic sel, input logic [7:0] a, input logic [11:0] d);
        if (sel) begin
            req1 = 1'b1; addr1 = a; data1 = d;
        end else begin
            req0 = 1'b1; addr0 = a; data0 = d;
        end
    endtask

    task automatic drop_req(input logic sel);
        if (sel) req1 = 1'b0;
        else     req0 = 1'b0;
    endtask

    task automatic fill_model(input logic [11:0] c);
        for (int i = 0; i < 192; i++) exp_mem[i] = c;
    endtask

    task automatic check_line(input int v);
        logic [11:0] e;
        set_pos(799, (v == 0) ? 524 : v - 1);
        cycle();
        for (int h = 0; h < 640; h++) begin
            e = exp_mem[(v / 40) * 16 + h / 40];
            check({red_out, green_out, blue_out} === e, "pixel",
                  {red_out, green_out, blue_out}, e);
            cycle();
        end
    endtask

    task automatic check_all_rows();
        for (int r = 0; r < 12; r++) check_line(r * 40 + (r * 7) % 40);
    endtask

    task automatic wait_busy_low(input int limit, output int cnt);
        cnt = 0;
        while (busy !== 1'b0 && cnt < limit) begin
            cycle();
            cnt++;
        end
        check(busy === 1'b0, "busy_timeout", busy, 0);
    endtask

    initial begin
        int cnt;
        int lat;
        int n0;
        int n1;
        int guard;
        bit upd0;
        bit upd1;
        logic [11:0] d0 [6];
        logic [11:0] d1 [6];

        vecs[0] = '{1'b0, 8'd17,  12'hF00, 100, 200, 1'b0, 1};
        vecs[1] = '{1'b1, 8'd3,   12'h00F, 79,  0,   1'b0, 2};
        vecs[2] = '{1'b0, 8'd200, 12'hFFF, 300, 10,  1'b1, 1};
        vecs[3] = '{1'b1, 8'd191, 12'h123, 799, 524, 1'b0, 2};
        vecs[4] = '{1'b0, 8'd0,   12'h456, 599, 479, 1'b0, 2};
        vecs[5] = '{1'b1, 8'd192, 12'h777, 639, 100, 1'b1, 1};
        vecs[6] = '{1'b0, 8'd16,  12'h0A5, 799, 478, 1'b0, 2};
        vecs[7] = '{1'b1, 8'd180, 12'hF0F, 799, 479, 1'b0, 1};

        rst = 1'b0;
        hc = 10'd0; vc = 10'd0;
        req0 = 1'b0; addr0 = '0; data0 = '0;
        req1 = 1'b0; addr1 = '0; data1 = '0;
        clr = 1'b0; clr_color = '0;
        repeat (3) cycle();
        rst = 1'b1;
        wait_busy_low(400, cnt);
        fill_model(12'h000);

        // Reset pulse mid-line, then the automatic clear.
        set_pos(300, 100);
        rst = 1'b0;
        #1;
        check(busy === 1'b1, "reset_busy", busy, 1);
        check({ack0, ack1, err} === 3'b000, "reset_acks", {ack0, ack1, err}, 0);
        check({red_out, green_out, blue_out} === 12'h000, "reset_pix",
              {red_out, green_out, blue_out}, 0);
        cycle();
        cycle();
        rst = 1'b1;
        check(busy === 1'b1, "busy_after_release", busy, 1);
        wait_busy_low(200, cnt);
        check(cnt <= 200, "clear_duration_active", cnt, 200);
        fill_model(12'h000);
        check_all_rows();

        // Single writes from a vector table, covering scan-slot collisions and bad addresses.
        foreach (vecs[i]) begin
            lat = 0;
            set_pos(vecs[i].h, vecs[i].v);
            drive_req(vecs[i].sel, vecs[i].addr, vecs[i].data);
            exp_q.push_back({vecs[i].sel, vecs[i].exp_err, vecs[i].addr, vecs[i].data});
            for (int c = 1; c <= 4 && lat == 0; c++) begin
                cycle();
                if ((vecs[i].sel ? ack1 : ack0) === 1'b1) lat = c;
            end
            check(lat == vecs[i].exp_lat, "write_latency", lat, vecs[i].exp_lat);
            cycle();
            drop_req(vecs[i].sel);
        end
        check_all_rows();

        // Clear during vertical blanking takes exactly one cycle per tile.
        set_pos(0, 490);
        clr = 1'b1; clr_color = 12'h000;
        cycle();
        clr = 1'b0;
        check(busy === 1'b1, "blank_clear_busy", busy, 1);
        wait_busy_low(300, cnt);
        check(cnt == 192, "clear_duration_blank", cnt, 192);
        fill_model(12'h000);

        // Round-robin with both requesters held; last grant went to requester 1.
        for (int k = 0; k < 6; k++) begin
            d0[k] = 12'($urandom_range(0, 4095));
            d1[k] = 12'($urandom_range(0, 4095));
            exp_q.push_back({1'b0, 1'b0, 8'(150 + k), d0[k]});
            exp_q.push_back({1'b1, 1'b0, 8'(100 + k), d1[k]});
        end
        set_pos(200, 150);
        drive_req(1'b0, 8'd150, d0[0]);
        drive_req(1'b1, 8'd100, d1[0]);
        n0 = 0; n1 = 0; upd0 = 1'b0; upd1 = 1'b0; guard = 0;
        while ((n0 < 6 || n1 < 6) && guard < 100) begin
            cycle();
            guard++;
            if (upd0) begin
                upd0 = 1'b0;
                if (n0 < 6) drive_req(1'b0, 8'(150 + n0), d0[n0]);
                else        drop_req(1'b0);
            end
            if (upd1) begin
                upd1 = 1'b0;
                if (n1 < 6) drive_req(1'b1, 8'(100 + n1), d1[n1]);
                else        drop_req(1'b1);
            end
            if (ack0 === 1'b1) begin n0++; upd0 = 1'b1; end
            if (ack1 === 1'b1) begin n1++; upd1 = 1'b1; end
        end
        check(n0 == 6, "rr_grants0", n0, 6);
        check(n1 == 6, "rr_grants1", n1, 6);
        check(guard <= 16, "rr_throughput", guard, 16);
        cycle();
        drop_req(1'b0);
        drop_req(1'b1);
        check_line(240);
        check_line(360);

        // Clear mid-frame with a held request and an ignored second clr pulse.
        set_pos(200, 300);
        clr = 1'b1; clr_color = 12'h0F0;
        drive_req(1'b0, 8'd50, 12'hABC);
        exp_q.push_back({1'b0, 1'b0, 8'd50, 12'hABC});
        cycle();
        clr = 1'b0; clr_color = 12'h000;
        check(busy === 1'b1, "clr_busy", busy, 1);
        repeat (5) cycle();
        clr = 1'b1; clr_color = 12'hF00;
        cycle();
        clr = 1'b0; clr_color = 12'h000;
        check(busy === 1'b1, "clr_still_busy", busy, 1);
        wait_busy_low(300, cnt);
        fill_model(12'h0F0);
        lat = 0;
        for (int c = 1; c <= 4 && lat == 0; c++) begin
            cycle();
            if (ack0 === 1'b1) lat = c;
        end
        check(lat == 1, "held_req_ack", lat, 1);
        cycle();
        drop_req(1'b0);
        check_all_rows();

        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
